traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Phase sequencer for the two-way (north/west) intersection. Steps through
//  green -> yellow -> all-red for each direction on a 1 Hz tick, with per-phase
//  durations and a live countdown. Drives the six *_time_pos light requests
//  that the LED output register stage consumes, and exports phase/remain for
//  the countdown display.
// PARAMETERS
//  GREEN_T   30  green duration in ticks, same for both directions (1..2**CNT_W)
//  YELLOW_T  3   yellow duration in ticks (1..2**CNT_W)
//  ALLRED_T  2   all-red clearance duration in ticks (1..2**CNT_W)
//  CNT_W     6   countdown width; each *_T must be <= 2**CNT_W
// PORTS
//  clk                    in   1      system clock
//  rst_n                  in   1      async active-low reset
//  sec_tick               in   1      1-cycle strobe, once per second
//  en                     in   1      1 = run; 0 = freeze phase and countdown
//  night_req              in   1      night flash request (only with NIGHT_FLASH_EN)
//  north_red_time_pos     out  1      north red request
//  north_green_time_pos   out  1      north green request
//  north_yellow_time_pos  out  1      north yellow request
//  west_red_time_pos      out  1      west red request
//  west_green_time_pos    out  1      west green request
//  west_yellow_time_pos   out  1      west yellow request
//  phase                  out  3      current state code (see below)
//  remain                 out  CNT_W  ticks left in phase minus 1 (0 = last second)
//  phase_done             out  1      1-cycle pulse on every phase change
// BEHAVIOUR
//  - Reset: rst_n is asynchronous, active-low; clock is clk. All state
//    registers and outputs are async-reset.
//  - States/codes: NS_GRN=0, NS_YEL=1, RED_A=2, WE_GRN=3, WE_YEL=4, RED_B=5,
//    FLASH=6 (exists only with macro).
//  - Order: RED_B -> NS_GRN -> NS_YEL -> RED_A -> WE_GRN -> WE_YEL -> RED_B.
//  - Reset values: state=RED_B, remain=ALLRED_T-1, north_red=1, west_red=1,
//    all other lights 0, phase_done=0.
//  - Countdown: advance only when en && sec_tick. If remain!=0, remain-1.
//    If remain==0, state<=next state and remain<=next_T-1 at the same edge.
//  - phase_done: registered; high exactly one cycle, the cycle after the
//    state register changes.
//  - Lights: registered decode of the state register; 1-cycle latency after
//    phase changes. Exactly one light per direction is high (except FLASH).
//    *_GRN lights own green and the other direction's red. *_YEL lights own
//    yellow and the other direction's red. RED_A/RED_B: both reds.
//  - en=0: state, remain and lights hold; sec_tick is ignored (no catch-up).
//    sec_tick coincident with the en 0->1 edge is ignored. Only the cycle
//    where en is already 1 counts.
//  - Green never follows green without yellow + all-red. No illegal code is
//    reachable. Any unused code recovers to RED_B with remain=ALLRED_T-1.
//  - Reset asserted mid-phase: immediate return to reset values. After
//    release, the first counted tick decrements from ALLRED_T-1.
// CONFIGURATION
//  - Macro NIGHT_FLASH_EN defined: night_req port and FLASH state exist.
//    night_req is sampled only at a counted tick with remain==0 in RED_A or
//    RED_B; if high, go to FLASH instead of the next green.
//  - In FLASH: all reds/greens 0; both yellows equal, toggle on every counted
//    tick (start at 1); remain holds 0.
//  - Exit FLASH on a counted tick with night_req==0: go to RED_B with
//    remain=ALLRED_T-1.
//  - Macro undefined: no night_req port, no FLASH logic; code 6 is unused.
// TESTING
//  1 Reset: rst_n=0 -> north_red=west_red=1, others 0, phase=5,
//    remain=ALLRED_T-1, phase_done=0.
//  2 GREEN_T=5, YELLOW_T=2, ALLRED_T=1, en=1, tick every 4 clk. Sequence:
//    RED_B 1 tick, NS_GRN 5 ticks, NS_YEL 2, RED_A 1, WE_GRN 5, WE_YEL 2.
//    Full cycle = 16 ticks, then back to NS_GRN. remain is 4,3,2,1,0 in
//    green. Lights lag phase by 1 clk.
//  3 en=0 for 10 ticks mid NS_GRN (remain=2) -> remain stays 2, lights hold.
//    Tick on en rise ignored. Next counted tick -> remain=1.
//  4 Assert rst_n=0 asynchronously mid WE_YEL (between edges) -> outputs
//    reset immediately. Release -> sequence restarts from RED_B.
//  5 NIGHT_FLASH_EN, night_req=1 during WE_GRN -> FLASH is entered only at
//    the end of RED_B. Yellows toggle 1,0,1 per tick. night_req=0 ->
//    RED_B, then NS_GRN.
//  6 phase_done: count pulses across one full cycle = 6; never 2 cycles wide.

Source files
------------

// File: rtl/traffic_phase_ctrl_if.sv
// Intersection light-phase bus: tick/enable in, six light requests plus phase/countdown out.
// Pure wiring; no storage, so it adds no latency.
// No flow control; the controller consumes the tick strobe unconditionally. NIGHT_FLASH_EN adds night_req.
interface traffic_phase_ctrl_if #(
   parameter int CNT_W = 6
);
   logic             sec_tick;
   logic             en;
`ifdef NIGHT_FLASH_EN
   logic             night_req;
`endif
   logic             north_red_time_pos;
   logic             north_green_time_pos;
   logic             north_yellow_time_pos;
   logic             west_red_time_pos;
   logic             west_green_time_pos;
   logic             west_yellow_time_pos;
   logic [2:0]       phase;
   logic [CNT_W-1:0] remain;
   logic             phase_done;

   // Controller side
   modport master (
      input  sec_tick,
      input  en,
`ifdef NIGHT_FLASH_EN
      input  night_req,
`endif
      output north_red_time_pos,
      output north_green_time_pos,
      output north_yellow_time_pos,
      output west_red_time_pos,
      output west_green_time_pos,
      output west_yellow_time_pos,
      output phase,
      output remain,
      output phase_done
   );

   // Timebase / LED register stage side
   modport slave (
      output sec_tick,
      output en,
`ifdef NIGHT_FLASH_EN
      output night_req,
`endif
      input  north_red_time_pos,
      input  north_green_time_pos,
      input  north_yellow_time_pos,
      input  west_red_time_pos,
      input  west_green_time_pos,
      input  west_yellow_time_pos,
      input  phase,
      input  remain,
      input  phase_done
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// North/west phase sequencer: green -> yellow -> all-red per direction, counted on 1 Hz ticks.
// Phase/remain update on the counted tick edge; lights and phase_done follow one clk later.
// No backpressure; ticks arriving while en=0 (or on the en rising cycle) are dropped. Optional NIGHT_FLASH_EN.
module traffic_phase_ctrl #(
   parameter int GREEN_T  = 30,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int CNT_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   traffic_phase_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      NS_GRN = 3'd0,
      NS_YEL = 3'd1,
      RED_A  = 3'd2,
      WE_GRN = 3'd3,
      WE_YEL = 3'd4,
      RED_B  = 3'd5
`ifdef NIGHT_FLASH_EN
      , FLASH = 3'd6
`endif
   } state_t;

   // Countdown reload values: the counter holds "ticks left minus one".
   localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   // Light vector order: {n_red, n_green, n_yellow, w_red, w_green, w_yellow}
   localparam logic [5:0] L_BOTH_RED = 6'b100_100;

   state_t           state;
   state_t           prev_state;
   state_t           nxt_state;
   logic [CNT_W-1:0] remain;
   logic [CNT_W-1:0] nxt_load;
   logic [5:0]       lights_q;
   logic             phase_done_q;
   logic             en_d;
   logic             step;
`ifdef NIGHT_FLASH_EN
   logic             flash_yel;
`endif

   // A tick counts only when en was already high on the previous cycle, so a
   // tick landing on the enable rising edge is dropped.
   assign step = bus.en && en_d && bus.sec_tick;

   function automatic logic [5:0] decode(input state_t s);
      case (s)
         NS_GRN:  decode = 6'b010_100;
         NS_YEL:  decode = 6'b001_100;
         WE_GRN:  decode = 6'b100_010;
         WE_YEL:  decode = 6'b100_001;
         default: decode = L_BOTH_RED;
      endcase
   endfunction

   // Successor phase and its countdown reload when the current phase expires.
   always_comb begin
      nxt_state = RED_B;
      nxt_load  = AR_LD;
      case (state)
         RED_B:   begin nxt_state = NS_GRN; nxt_load = G_LD;  end
         NS_GRN:  begin nxt_state = NS_YEL; nxt_load = Y_LD;  end
         NS_YEL:  begin nxt_state = RED_A;  nxt_load = AR_LD; end
         RED_A:   begin nxt_state = WE_GRN; nxt_load = G_LD;  end
         WE_GRN:  begin nxt_state = WE_YEL; nxt_load = Y_LD;  end
         WE_YEL:  begin nxt_state = RED_B;  nxt_load = AR_LD; end
         default: begin nxt_state = RED_B;  nxt_load = AR_LD; end
      endcase
`ifdef NIGHT_FLASH_EN
      // Night flash can only be entered from an all-red clearance phase.
      if ((state == RED_A || state == RED_B) && bus.night_req) begin
         nxt_state = FLASH;
         nxt_load  = '0;
      end
`endif
   end

   // Phase FSM with countdown, registered light decode and change pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RED_B;
         prev_state   <= RED_B;
         remain       <= AR_LD;
         lights_q     <= L_BOTH_RED;
         phase_done_q <= 1'b0;
         en_d         <= 1'b0;
`ifdef NIGHT_FLASH_EN
         flash_yel    <= 1'b0;
`endif
      end else begin
         en_d         <= bus.en;
         prev_state   <= state;
         phase_done_q <= (state != prev_state);
         lights_q     <= decode(state);
`ifdef NIGHT_FLASH_EN
         if (state == FLASH)
            lights_q <= {2'b00, flash_yel, 2'b00, flash_yel};
`endif
         case (state)
            NS_GRN, NS_YEL, RED_A, WE_GRN, WE_YEL, RED_B: begin
               if (step) begin
                  if (remain != '0) begin
                     remain <= remain - ONE;
                  end else begin
                     state  <= nxt_state;
                     remain <= nxt_load;
`ifdef NIGHT_FLASH_EN
                     if (nxt_state == FLASH)
                        flash_yel <= 1'b1;
`endif
                  end
               end
            end
`ifdef NIGHT_FLASH_EN
            FLASH: begin
               if (step) begin
                  if (!bus.night_req) begin
                     state  <= RED_B;
                     remain <= AR_LD;
                  end else begin
                     flash_yel <= ~flash_yel;
                  end
               end
            end
`endif
            default: begin
               // Unused code: fall back to a safe all-red clearance.
               state  <= RED_B;
               remain <= AR_LD;
            end
         endcase
      end
   end

   assign bus.north_red_time_pos    = lights_q[5];
   assign bus.north_green_time_pos  = lights_q[4];
   assign bus.north_yellow_time_pos = lights_q[3];
   assign bus.west_red_time_pos     = lights_q[2];
   assign bus.west_green_time_pos   = lights_q[1];
   assign bus.west_yellow_time_pos  = lights_q[0];
   assign bus.phase                 = state;
   assign bus.remain                = remain;
   assign bus.phase_done            = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a phase/duration reference model.
// Checks every cycle: phase/remain immediately, lights and phase_done one clk behind.
// Flash scenario runs only when NIGHT_FLASH_EN is defined.
module tb_traffic_phase_ctrl;
   localparam int G  = 5;
   localparam int Y  = 2;
   localparam int AR = 1;
   localparam int W  = 6;
`ifdef NIGHT_FLASH_EN
   localparam bit FLASH_ON = 1'b1;
`else
   localparam bit FLASH_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   traffic_phase_ctrl_if #(.CNT_W(W)) bus ();

   traffic_phase_ctrl #(
      .GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(AR), .CNT_W(W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.master)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: phase code, ticks-left-minus-one, flash yellow level,
   // plus the two previous samples of phase (lights/phase_done lag by one clk).
   int ph, p1, p2, rem;
   bit fy, fy1, en_prev;
   int pd_count, pd_wide;
   bit pd_last;

   // Duration by position in the green/yellow/all-red triple.
   function automatic int dur(input int c);
      if (c % 3 == 0) return G;
      if (c % 3 == 1) return Y;
      return AR;
   endfunction

   // {n_red, n_green, n_yellow, w_red, w_green, w_yellow}
   function automatic logic [5:0] lights_of(input int c, input bit f);
      case (c)
         0:       return 6'b010_100;
         1:       return 6'b001_100;
         3:       return 6'b100_010;
         4:       return 6'b100_001;
         6:       return {2'b00, f, 2'b00, f};
         default: return 6'b100_100;
      endcase
   endfunction

   function automatic logic [5:0] dut_lights();
      return {bus.north_red_time_pos, bus.north_green_time_pos, bus.north_yellow_time_pos,
              bus.west_red_time_pos, bus.west_green_time_pos, bus.west_yellow_time_pos};
   endfunction

   task automatic model_reset();
      ph = 5; p1 = 5; p2 = 5; rem = AR - 1;
      fy = 1'b0; fy1 = 1'b0; en_prev = 1'b0;
      pd_last = 1'b0;
   endtask

   task automatic set_inputs(input bit tk, input bit e, input bit nr);
      bus.sec_tick = tk;
      bus.en       = e;
`ifdef NIGHT_FLASH_EN
      bus.night_req = nr;
`endif
   endtask

   // One clock: drive inputs, advance model on the edge, compare all outputs.
   task automatic step(input bit tk, input bit e, input bit nr);
      logic [5:0] exp_l;
      set_inputs(tk, e, nr);
      @(posedge clk);
      #1;
      p2 = p1; p1 = ph; fy1 = fy;
      if (tk && e && en_prev) begin
         if (ph == 6) begin
            if (!nr) begin ph = 5; rem = AR - 1; end
            else fy = ~fy;
         end else if (rem != 0) begin
            rem = rem - 1;
         end else if (FLASH_ON && nr && (ph == 2 || ph == 5)) begin
            ph = 6; rem = 0; fy = 1'b1;
         end else begin
            ph = (ph + 1) % 6;
            rem = dur(ph) - 1;
         end
      end
      en_prev = e;
      exp_l = lights_of(p1, fy1);
      checks++;
      if (bus.phase !== 3'(ph)) begin
         errors++; $display("FAIL phase t=%0t got %0d want %0d", $time, bus.phase, ph);
      end
      checks++;
      if (bus.remain !== W'(rem)) begin
         errors++; $display("FAIL remain t=%0t got %0d want %0d", $time, bus.remain, rem);
      end
      checks++;
      if (dut_lights() !== exp_l) begin
         errors++; $display("FAIL lights t=%0t got %b want %b", $time, dut_lights(), exp_l);
      end
      checks++;
      if (bus.phase_done !== (p1 != p2)) begin
         errors++; $display("FAIL phase_done t=%0t got %b want %b", $time, bus.phase_done, (p1 != p2));
      end
      if (bus.phase_done === 1'b1) begin
         pd_count++;
         if (pd_last) pd_wide++;
      end
      pd_last = (bus.phase_done === 1'b1);
   endtask

   // One counted tick followed by three idle clocks (tick every 4 clk).
   task automatic tick4(input bit e, input bit nr);
      step(1'b1, e, nr);
      repeat (3) step(1'b0, e, nr);
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if (bus.phase !== 3'd5) begin errors++; $display("FAIL %s_phase got %0d want 5", tag, bus.phase); end
      checks++;
      if (bus.remain !== W'(AR - 1)) begin errors++; $display("FAIL %s_remain got %0d want %0d", tag, bus.remain, AR - 1); end
      checks++;
      if (dut_lights() !== 6'b100_100) begin errors++; $display("FAIL %s_lights got %b want 100100", tag, dut_lights()); end
      checks++;
      if (bus.phase_done !== 1'b0) begin errors++; $display("FAIL %s_pdone got %b want 0", tag, bus.phase_done); end
   endtask

   task automatic test_reset();
      set_inputs(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #23;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_sequence();
      step(1'b0, 1'b1, 1'b0);
      pd_count = 0; pd_wide = 0;
      repeat (16) tick4(1'b1, 1'b0);
      checks++;
      if (pd_count !== 6) begin errors++; $display("FAIL pd_per_cycle got %0d want 6", pd_count); end
      checks++;
      if (pd_wide !== 0) begin errors++; $display("FAIL pd_width got %0d wide want 0", pd_wide); end
      checks++;
      if (bus.phase !== 3'd5) begin errors++; $display("FAIL cycle_end got %0d want 5", bus.phase); end
      tick4(1'b1, 1'b0);
      checks++;
      if (bus.phase !== 3'd0 || bus.remain !== W'(G - 1)) begin
         errors++; $display("FAIL wrap_ns_grn got %0d/%0d want 0/%0d", bus.phase, bus.remain, G - 1);
      end
   endtask

   task automatic test_enable_freeze();
      repeat (2) tick4(1'b1, 1'b0);
      checks++;
      if (bus.remain !== W'(2) || bus.phase !== 3'd0) begin
         errors++; $display("FAIL pre_freeze got %0d/%0d want 0/2", bus.phase, bus.remain);
      end
      for (int k = 0; k < 40; k++) step(k % 4 == 0, 1'b0, 1'b0);
      checks++;
      if (bus.remain !== W'(2) || dut_lights() !== 6'b010_100) begin
         errors++; $display("FAIL freeze got %0d/%b want 2/010100", bus.remain, dut_lights());
      end
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.remain !== W'(2)) begin errors++; $display("FAIL en_rise_tick got %0d want 2", bus.remain); end
      repeat (3) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.remain !== W'(1)) begin errors++; $display("FAIL after_freeze got %0d want 1", bus.remain); end
   endtask

   task automatic test_async_reset();
      int n = 0;
      while (ph != 4 && n < 40) begin tick4(1'b1, 1'b0); n++; end
      checks++;
      if (ph != 4) begin errors++; $display("FAIL reach_we_yel got %0d want 4", ph); end
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      tick4(1'b1, 1'b0);
      checks++;
      if (bus.phase !== 3'd0 || bus.remain !== W'(G - 1)) begin
         errors++; $display("FAIL restart got %0d/%0d want 0/%0d", bus.phase, bus.remain, G - 1);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         bit nr;
         nr = FLASH_ON ? ($urandom % 4 == 0) : 1'b0;
         step($urandom % 3 == 0, $urandom % 8 != 0, nr);
      end
   endtask

`ifdef NIGHT_FLASH_EN
   task automatic test_flash();
      int n = 0;
      int last_ph;
      while (ph == 6 && n < 10) begin tick4(1'b1, 1'b0); n++; end
      n = 0;
      while (ph != 3 && n < 40) begin tick4(1'b1, 1'b0); n++; end
      last_ph = ph;
      n = 0;
      while (ph != 6 && n < 40) begin
         last_ph = ph;
         tick4(1'b1, 1'b1);
         n++;
      end
      checks++;
      if (ph != 6 || last_ph != 5) begin
         errors++; $display("FAIL flash_entry got %0d from %0d want 6 from 5", ph, last_ph);
      end
      checks++;
      if (bus.north_yellow_time_pos !== 1'b1 || bus.west_yellow_time_pos !== 1'b1) begin
         errors++; $display("FAIL flash_y1 got %b%b want 11", bus.north_yellow_time_pos, bus.west_yellow_time_pos);
      end
      tick4(1'b1, 1'b1);
      checks++;
      if (bus.north_yellow_time_pos !== 1'b0) begin errors++; $display("FAIL flash_y0 got %b want 0", bus.north_yellow_time_pos); end
      tick4(1'b1, 1'b1);
      checks++;
      if (bus.west_yellow_time_pos !== 1'b1) begin errors++; $display("FAIL flash_y1b got %b want 1", bus.west_yellow_time_pos); end
      tick4(1'b1, 1'b0);
      checks++;
      if (bus.phase !== 3'd5) begin errors++; $display("FAIL flash_exit got %0d want 5", bus.phase); end
      tick4(1'b1, 1'b0);
      checks++;
      if (bus.phase !== 3'd0) begin errors++; $display("FAIL flash_to_grn got %0d want 0", bus.phase); end
   endtask
`endif

   initial begin
      test_reset();
      test_sequence();
      test_enable_freeze();
      test_async_reset();
`ifdef NIGHT_FLASH_EN
      test_flash();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
